// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
//   Shared types and defaults for the iterative RV64M divider.
//   - div_op_t    : operation encoding, equal to funct3[1:0] of DIV/DIVU/REM/REMU
//   - div_state_t : divider control FSM states
//   - XLEN_DEF    : default operand/result width
//   - op_is_signed / op_is_rem : operation decode helpers
// -----------------------------------------------------------------------------
package div_pkg;

  localparam int XLEN_DEF = 64;

  typedef enum logic [1:0] {
    DIV_S = 2'b00,
    DIV_U = 2'b01,
    REM_S = 2'b10,
    REM_U = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } div_state_t;

  function automatic logic op_is_signed(input div_op_t op);
    return (op == DIV_S) || (op == REM_S);
  endfunction

  function automatic logic op_is_rem(input div_op_t op);
    return (op == REM_S) || (op == REM_U);
  endfunction

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
//   One combinational radix-2 restoring division iteration.
//   The partial remainder is shifted left taking the dividend MSB; if the
//   result is at least the divisor it is reduced and a 1 enters the quotient.
// Ports:
//   rem_in   in  XLEN  partial remainder before this iteration
//   quo_in   in  XLEN  dividend/quotient shift register before this iteration
//   divisor  in  XLEN  divisor magnitude
//   rem_out  out XLEN  partial remainder after this iteration
//   quo_out  out XLEN  shift register after this iteration (new bit at LSB)
// -----------------------------------------------------------------------------
module div_step
  import div_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quo_out
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;
  logic          fits;

  always_comb begin
    shifted = {rem_in, quo_in[XLEN-1]};
    diff    = shifted - {1'b0, divisor};
    // shifted < 2*divisor always, so a non-negative difference fits in XLEN
    // bits and the top bit of the XLEN+1 subtraction is exactly the borrow.
    fits    = ~diff[XLEN];
    rem_out = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    quo_out = {quo_in[XLEN-2:0], fits};
  end

endmodule

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
//   Multi-cycle radix-2 restoring integer divider for RV64M DIV/DIVU/REM/REMU.
//   One quotient bit per cycle; valid/ready handshake on request and response.
//   Divide-by-zero and signed overflow are resolved at accept without iterating.
//   Optional macro DIV_WORD_OP_EN adds req_w for the 32-bit *W variants.
// Ports:
//   clk         in   1     rising-edge clock
//   reset_n     in   1     asynchronous active-low reset
//   flush       in   1     abort any in-flight operation
//   req_valid   in   1     request operands valid
//   req_ready   out  1     unit idle and able to accept
//   req_op      in   2     div_op_t operation
//   req_a       in   XLEN  dividend
//   req_b       in   XLEN  divisor
//   req_w       in   1     word operation (only with DIV_WORD_OP_EN)
//   resp_valid  out  1     result valid
//   resp_ready  in   1     consumer accepts result
//   resp_data   out  XLEN  quotient or remainder
// -----------------------------------------------------------------------------
module div_unit
  import div_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  div_op_t         req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
`ifdef DIV_WORD_OP_EN
  input  logic            req_w,
`endif
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data
);

  localparam int              CNT_W   = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

`ifdef DIV_WORD_OP_EN
  localparam logic [XLEN-1:0] MASK32  = {{(XLEN-32){1'b0}}, 32'hFFFF_FFFF};
  localparam logic [XLEN-1:0] MIN_W   = {{(XLEN-31){1'b1}}, {31{1'b0}}};

  function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
    return v[31] ? (v | ~MASK32) : (v & MASK32);
  endfunction

  function automatic logic [XLEN-1:0] zext32(input logic [XLEN-1:0] v);
    return v & MASK32;
  endfunction
`endif

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v,
                                               input logic            neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  div_state_t      state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0] quo, rem, dvsr;
  logic            q_neg, r_neg;
  div_op_t         op_q;
`ifdef DIV_WORD_OP_EN
  logic            word_q;
`endif
  logic            resp_valid_q;
  logic [XLEN-1:0] resp_data_q;

  logic [XLEN-1:0] quo_step, rem_step;

  // accept-side decode
  logic             signed_in, a_neg, b_neg, div_zero, ovf, special;
  logic [XLEN-1:0]  a_ext, b_ext, min_val, mag_a, mag_b;
  logic [XLEN-1:0]  spec_quo, spec_rem, quo_init;
  logic [CNT_W-1:0] cnt_init;
  logic             accept;

  // result fix-up
  logic [XLEN-1:0] result;

  div_step #(.XLEN(XLEN)) u_step (
    .rem_in  (rem),
    .quo_in  (quo),
    .divisor (dvsr),
    .rem_out (rem_step),
    .quo_out (quo_step)
  );

  assign req_ready  = (state == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign accept     = (state == IDLE) && req_valid && !flush;

  always_comb begin
    signed_in = op_is_signed(req_op);
    a_ext     = req_a;
    b_ext     = req_b;
    min_val   = MIN_INT;
`ifdef DIV_WORD_OP_EN
    if (req_w) begin
      a_ext   = signed_in ? sext32(req_a) : zext32(req_a);
      b_ext   = signed_in ? sext32(req_b) : zext32(req_b);
      min_val = MIN_W;
    end
`endif
    a_neg    = signed_in & a_ext[XLEN-1];
    b_neg    = signed_in & b_ext[XLEN-1];
    mag_a    = cond_neg(a_ext, a_neg);
    mag_b    = cond_neg(b_ext, b_neg);
    div_zero = (b_ext == '0);
    ovf      = signed_in && (a_ext == min_val) && (b_ext == '1);
    special  = div_zero || ovf;
    // Special results are parked in quo/rem with no sign flags so the
    // regular DONE fix-up passes them through unchanged.
    spec_quo = div_zero ? '1 : a_ext;
    spec_rem = div_zero ? a_ext : '0;
    quo_init = mag_a;
    cnt_init = CNT_W'(XLEN-1);
`ifdef DIV_WORD_OP_EN
    if (req_w) begin
      // Word magnitudes fit in 32 bits; park them at the top so only 32
      // iterations are needed and the quotient lands in the low half.
      quo_init = mag_a << 32;
      cnt_init = CNT_W'(31);
    end
`endif
  end

  always_comb begin
    result = op_is_rem(op_q) ? cond_neg(rem, r_neg) : cond_neg(quo, q_neg);
`ifdef DIV_WORD_OP_EN
    if (word_q) result = sext32(result);
`endif
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (req_valid) state_next = special ? DONE : CALC;
        CALC:    if (cnt == '0) state_next = DONE;
        DONE:    if (resp_valid_q && resp_ready) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // accept / iterate / respond
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt          <= '0;
      quo          <= '0;
      rem          <= '0;
      dvsr         <= '0;
      q_neg        <= 1'b0;
      r_neg        <= 1'b0;
      op_q         <= DIV_S;
`ifdef DIV_WORD_OP_EN
      word_q       <= 1'b0;
`endif
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
    end else if (flush) begin
      resp_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q <= req_op;
            dvsr <= mag_b;
            cnt  <= cnt_init;
`ifdef DIV_WORD_OP_EN
            word_q <= req_w;
`endif
            if (special) begin
              quo   <= spec_quo;
              rem   <= spec_rem;
              q_neg <= 1'b0;
              r_neg <= 1'b0;
            end else begin
              quo   <= quo_init;
              rem   <= '0;
              q_neg <= a_neg ^ b_neg;
              r_neg <= a_neg;
            end
          end
        end
        CALC: begin
          quo <= quo_step;
          rem <= rem_step;
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        DONE: begin
          // First DONE cycle registers the result; afterwards it is held
          // until the consumer takes it.
          if (!resp_valid_q) begin
            resp_data_q  <= result;
            resp_valid_q <= 1'b1;
          end else if (resp_ready) begin
            resp_valid_q <= 1'b0;
          end
        end
        default: resp_valid_q <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;
  import div_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  div_op_t     req_op;
  logic [63:0] req_a;
  logic [63:0] req_b;
`ifdef DIV_WORD_OP_EN
  logic        req_w;
`endif
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_data;

  typedef struct {
    logic [63:0] data;
    int          lat;
    int          acc;
    string       name;
  } exp_t;

  exp_t  sb[$];
  exp_t  popped;
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  logic  prev_valid = 1'b0;

  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

  div_unit #(.XLEN(64)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
`ifdef DIV_WORD_OP_EN
    .req_w      (req_w),
`endif
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  // Monitor: latency on the first valid cycle, data on the handshake.
  always @(negedge clk) begin
    if (reset_n) begin
      if (resp_valid && !prev_valid) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_resp: got resp_valid=1 data=0x%h expected no response", resp_data);
        end else begin
          check({sb[0].name, "_lat"}, 64'(cyc - sb[0].acc), 64'(sb[0].lat));
        end
      end
      if (resp_valid && resp_ready && sb.size() != 0) begin
        popped = sb.pop_front();
        check(popped.name, resp_data, popped.data);
      end
      prev_valid = resp_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic issue(input div_op_t op, input logic [63:0] a, input logic [63:0] b,
                       input logic push, input logic [63:0] exp, input int lat,
                       input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      failures++;
      $display("FAIL %s_ready_timeout: got req_ready=0 expected 1", name);
    end
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    if (push) sb.push_back('{exp, lat, cyc + 1, name});
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || resp_valid) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || resp_valid) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got pending=%0d expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int n;
    reset_n    = 1'b0;
    flush      = 1'b0;
    req_valid  = 1'b0;
    req_op     = DIV_S;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b1;
`ifdef DIV_WORD_OP_EN
    req_w      = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_data", resp_data, 64'd0);
    reset_n = 1'b1;

    // Normal iterative ops
    issue(DIV_U, 64'd100, 64'd7, 1'b1, 64'd14, 65, "divu_100_7");       drain("t1");
    issue(REM_U, 64'd100, 64'd7, 1'b1, 64'd2, 65, "remu_100_7");        drain("t2");
    issue(DIV_S, -64'sd7, 64'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 65, "div_m7_2"); drain("t3");
    issue(REM_S, -64'sd7, 64'd2, 1'b1, ONES, 65, "rem_m7_2");           drain("t4");
    issue(REM_S, 64'd7, -64'sd2, 1'b1, 64'd1, 65, "rem_7_m2");          drain("t5");
    issue(DIV_S, -64'sd7, -64'sd2, 1'b1, 64'd3, 65, "div_m7_m2");       drain("t6");
    issue(DIV_U, ONES, 64'd16, 1'b1, 64'h0FFF_FFFF_FFFF_FFFF, 65, "divu_max_16"); drain("t7");

    // Special cases: 1-cycle latency
    issue(DIV_S, 64'd5, 64'd0, 1'b1, ONES, 1, "div_5_0");              drain("t8");
    issue(REM_U, 64'd5, 64'd0, 1'b1, 64'd5, 1, "remu_5_0");            drain("t9");
    issue(REM_S, 64'd5, 64'd0, 1'b1, 64'd5, 1, "rem_5_0");             drain("t10");
    issue(DIV_S, MIN64, ONES, 1'b1, MIN64, 1, "div_min_m1");           drain("t11");
    issue(REM_S, MIN64, ONES, 1'b1, 64'd0, 1, "rem_min_m1");           drain("t12");

    // Backpressure: result held stable, no new request accepted
    resp_ready = 1'b0;
    issue(DIV_U, 64'd100, 64'd7, 1'b1, 64'd14, 65, "bp_divu");
    n = 0;
    while (!resp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold_data", resp_data, 64'd14);
      check("bp_req_ready", 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    drain("t13");

    // Flush in the middle of CALC: nothing emitted, next op correct
    issue(DIV_U, 64'd1000, 64'd3, 1'b0, 64'd0, 0, "flushed_op");
    repeat (20) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_req_ready", 64'(req_ready), 64'd1);
    check("flush_resp_valid", 64'(resp_valid), 64'd0);
    repeat (70) @(negedge clk);
    issue(DIV_S, 64'd9, 64'd3, 1'b1, 64'd3, 65, "div_9_3");            drain("t14");

    // Flush wins over a simultaneous request
    @(negedge clk);
    req_op = DIV_S; req_a = 64'd5; req_b = 64'd0;
    req_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1 begin req_valid = 1'b0; flush = 1'b0; end
    repeat (3) @(negedge clk);
    check("flushwin_req_ready", 64'(req_ready), 64'd1);
    check("flushwin_resp_valid", 64'(resp_valid), 64'd0);

    // Asynchronous reset mid-operation
    issue(DIV_U, 64'd100, 64'd7, 1'b0, 64'd0, 0, "reset_op");
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("arst_resp_valid", 64'(resp_valid), 64'd0);
    check("arst_req_ready", 64'(req_ready), 64'd1);
    check("arst_resp_data", resp_data, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (70) @(negedge clk);
    issue(DIV_S, 64'd100, -64'sd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFF2, 65, "div_100_m7"); drain("t15");
    issue(REM_S, 64'd100, -64'sd7, 1'b1, 64'd2, 65, "rem_100_m7");     drain("t16");

`ifdef DIV_WORD_OP_EN
    req_w = 1'b1;
    issue(DIV_S, 64'h0000_0001_FFFF_FFF8, 64'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 33, "divw"); drain("t17");
    req_w = 1'b0;
`endif

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
